// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: strobes columns on a divided clock, debounces whole
// scans and reports one registered key code with a single-cycle valid pulse per accepted press.
module keypad_scanner #(
    parameter int unsigned g_SCAN_DIVIDE    = 100000,
    parameter int unsigned g_DEBOUNCE_SCANS = 4
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Row,
    output logic [3:0] o_Col,
    output logic [3:0] o_Key_Code,
    output logic       o_Key_Valid,
    output logic       o_Key_Held
);

    localparam int unsigned DivW = $clog2(g_SCAN_DIVIDE);
    localparam int unsigned CntW = $clog2(g_DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(g_SCAN_DIVIDE - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(g_DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ResNone,
        ResKey,
        ResMulti
    } res_kind_e;

    typedef enum logic {
        StIdle,
        StHeld
    } state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_drv_q, col_drv_d;
    logic [15:0]     snap_q, snap_d;
    res_kind_e       prev_kind_q, prev_kind_d;
    logic [3:0]      prev_code_q, prev_code_d;
    logic [CntW-1:0] stable_q, stable_d;
    state_e          state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            held_q, held_d;

    logic            tick;
    logic            scan_done;
    logic            is_stable;
    logic            same_result;
    res_kind_e       res_kind;
    logic [3:0]      res_code;
    logic [4:0]      n_low;
    logic [3:0]      low_idx;

    // Rows come straight off the keypad pins.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= i_Row;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick      = (div_q == DivLast);
    assign scan_done = tick && (col_idx_q == 2'd3);

    always_comb begin
        div_d     = div_q + 1'b1;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        if (tick) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                snap_d[{r[1:0], col_idx_q}] = row_sync_q[r];
            end
        end
        col_drv_d = ~(4'b0001 << col_idx_d);
    end

    // Classify the completed scan; the col3 sample is folded in through snap_d.
    always_comb begin
        n_low   = '0;
        low_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (!snap_d[i]) begin
                n_low   = n_low + 5'd1;
                low_idx = 4'(i);
            end
        end
        res_kind = ResMulti;
        res_code = '0;
        if (n_low == 5'd0) begin
            res_kind = ResNone;
        end else if (n_low == 5'd1) begin
            res_kind = ResKey;
            res_code = low_idx;
        end
    end

    assign same_result = (res_kind == prev_kind_q) && (res_code == prev_code_q);

    always_comb begin
        stable_d    = stable_q;
        prev_kind_d = prev_kind_q;
        prev_code_d = prev_code_q;
        if (scan_done) begin
            prev_kind_d = res_kind;
            prev_code_d = res_code;
            if (!same_result) begin
                stable_d = CntW'(1);
            end else if (stable_q < CntMax) begin
                stable_d = stable_q + 1'b1;
            end
        end
    end

    assign is_stable = scan_done && (stable_d >= CntMax);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (is_stable) begin
            unique case (state_q)
                StIdle: begin
                    if (res_kind == ResKey) begin
                        code_d  = res_code;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        state_d = StHeld;
                    end
                end
                StHeld: begin
                    // A different key replacing the held one is reported without a release.
                    if (res_kind == ResKey && res_code != code_q) begin
                        code_d  = res_code;
                        valid_d = 1'b1;
                    end else if (res_kind == ResNone) begin
                        held_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            div_q       <= '0;
            col_idx_q   <= '0;
            col_drv_q   <= 4'b1110;
            snap_q      <= 16'hFFFF;
            prev_kind_q <= ResNone;
            prev_code_q <= '0;
            stable_q    <= '0;
            state_q     <= StIdle;
            code_q      <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_drv_q   <= col_drv_d;
            snap_q      <= snap_d;
            prev_kind_q <= prev_kind_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
        end
    end

    assign o_Col       = col_drv_q;
    assign o_Key_Code  = code_q;
    assign o_Key_Valid = valid_q;
    assign o_Key_Held  = held_q;

endmodule
